subleq_core_param: RTL and testbench

- Parametrised, multi-cycle SUBLEQ processor core.
- Executes mem[B] <= mem[B] - mem[A]; jumps to C if the result is signed <= 0, else falls through to IP+1.
- Talks to an external single-port word memory through a req/ack handshake, so memory latency may vary.
- Adds run/step control, halt detection and a retired-instruction counter for system-level debug.

---
 rtl/subleq_core_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_subleq_core_param.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_core_param.sv
// Multi-cycle SUBLEQ core: mem[B] <= mem[B] - mem[A], branch to C when the result is <= 0.
// Memory is reached through a req/ack handshake so the external latency can vary.
module subleq_core_param #(
    parameter int          DATA_W            = 64,
    parameter int          ADDR_W            = 13,
    parameter int unsigned RESET_IP          = 0,
    parameter int          HALT_ON_SELF_JUMP = 1
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iRun,
    input  logic              iStep,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [ADDR_W-1:0] oIP,
    output logic [2:0]        oState,
    output logic              oHalted,
    output logic [31:0]       oRetired
);

    localparam int INSTR_W = 3 * ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_IP_W = ADDR_W'(RESET_IP);
    localparam bit HALT_EN = (HALT_ON_SELF_JUMP != 0);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WRITE  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ip_r;
    logic [ADDR_W-1:0]   ip_nxt;
    logic [INSTR_W-1:0]  instr_r;
    logic [INSTR_W-1:0]  instr_nxt;
    logic [DATA_W-1:0]   opa_r;
    logic [DATA_W-1:0]   opa_nxt;
    logic                leq_r;
    logic                leq_nxt;
    logic                step_pending_r;
    logic                step_pending_nxt;
    logic                mem_req_r;
    logic                mem_req_nxt;
    logic                mem_we_r;
    logic                mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic                halted_r;
    logic                halted_nxt;
    logic [31:0]         retired_r;
    logic [31:0]         retired_nxt;

    logic                ack_s;
    logic [ADDR_W-1:0]   field_b_s;
    logic [ADDR_W-1:0]   field_c_s;
    logic [ADDR_W-1:0]   rdata_a_s;
    logic [DATA_W-1:0]   sub_s;
    logic                leq_s;
    logic [ADDR_W-1:0]   ip_next_s;
    logic                self_halt_s;
    logic                step_set_s;
    logic                fetch_go_s;

    // Handshake qualification and instruction-field decode.
    always_comb begin
        ack_s       = iMemAck & mem_req_r;
        field_b_s   = instr_r[2*ADDR_W-1:ADDR_W];
        field_c_s   = instr_r[ADDR_W-1:0];
        rdata_a_s   = iMemRData[3*ADDR_W-1:2*ADDR_W];
        sub_s       = iMemRData - opa_r;
        leq_s       = sub_s[DATA_W-1] | (sub_s == {DATA_W{1'b0}});
        ip_next_s   = leq_r ? field_c_s : (ip_r + ADDR_W'(1));
        self_halt_s = HALT_EN & leq_r & (field_c_s == ip_r);
        step_set_s  = (state_r == ST_FETCH) & ~iRun & iStep;
        fetch_go_s  = iRun | step_pending_r | step_set_s;
    end

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic: every transition is gated by a qualified ack except HALT.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_FETCH: begin
                if (ack_s) state_nxt = ST_LOAD_A;
                else       state_nxt = ST_FETCH;
            end
            ST_LOAD_A: begin
                if (ack_s) state_nxt = ST_LOAD_B;
                else       state_nxt = ST_LOAD_A;
            end
            ST_LOAD_B: begin
                if (ack_s) state_nxt = ST_WRITE;
                else       state_nxt = ST_LOAD_B;
            end
            ST_WRITE: begin
                if (ack_s) state_nxt = self_halt_s ? ST_HALT : ST_FETCH;
                else       state_nxt = ST_WRITE;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    // Output and datapath next values; the next request is set up on the edge that completes the current one.
    always_comb begin
        ip_nxt           = ip_r;
        instr_nxt        = instr_r;
        opa_nxt          = opa_r;
        leq_nxt          = leq_r;
        step_pending_nxt = step_pending_r;
        mem_req_nxt      = mem_req_r;
        mem_we_nxt       = mem_we_r;
        mem_addr_nxt     = mem_addr_r;
        mem_wdata_nxt    = mem_wdata_r;
        halted_nxt       = halted_r;
        retired_nxt      = retired_r;
        case (state_r)
            ST_FETCH: begin
                if (ack_s) begin
                    instr_nxt        = iMemRData[INSTR_W-1:0];
                    step_pending_nxt = 1'b0;
                    mem_req_nxt      = 1'b1;
                    mem_we_nxt       = 1'b0;
                    mem_addr_nxt     = rdata_a_s;
                end else if (!mem_req_r) begin
                    step_pending_nxt = step_pending_r | step_set_s;
                    if (fetch_go_s) begin
                        mem_req_nxt  = 1'b1;
                        mem_we_nxt   = 1'b0;
                        mem_addr_nxt = ip_r;
                    end else begin
                        mem_req_nxt  = 1'b0;
                    end
                end else begin
                    step_pending_nxt = step_pending_r | step_set_s;
                end
            end
            ST_LOAD_A: begin
                if (ack_s) begin
                    opa_nxt      = iMemRData;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = field_b_s;
                end else begin
                    mem_req_nxt  = mem_req_r;
                end
            end
            ST_LOAD_B: begin
                // The write-data register doubles as the latched difference.
                if (ack_s) begin
                    leq_nxt       = leq_s;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = field_b_s;
                    mem_wdata_nxt = sub_s;
                end else begin
                    mem_req_nxt   = mem_req_r;
                end
            end
            ST_WRITE: begin
                if (ack_s) begin
                    if (retired_r != 32'hFFFF_FFFF) retired_nxt = retired_r + 32'd1;
                    else                            retired_nxt = retired_r;
                    if (self_halt_s) begin
                        mem_req_nxt = 1'b0;
                        mem_we_nxt  = 1'b0;
                        halted_nxt  = 1'b1;
                    end else begin
                        ip_nxt       = ip_next_s;
                        mem_req_nxt  = iRun;
                        mem_we_nxt   = 1'b0;
                        mem_addr_nxt = ip_next_s;
                    end
                end else begin
                    mem_req_nxt = mem_req_r;
                end
            end
            ST_HALT: begin
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
                halted_nxt  = 1'b1;
            end
            default: begin
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and registered-output storage; reset drops any in-flight request.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            ip_r           <= RESET_IP_W;
            instr_r        <= {INSTR_W{1'b0}};
            opa_r          <= {DATA_W{1'b0}};
            leq_r          <= 1'b0;
            step_pending_r <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
            halted_r       <= 1'b0;
            retired_r      <= 32'd0;
        end else begin
            ip_r           <= ip_nxt;
            instr_r        <= instr_nxt;
            opa_r          <= opa_nxt;
            leq_r          <= leq_nxt;
            step_pending_r <= step_pending_nxt;
            mem_req_r      <= mem_req_nxt;
            mem_we_r       <= mem_we_nxt;
            mem_addr_r     <= mem_addr_nxt;
            mem_wdata_r    <= mem_wdata_nxt;
            halted_r       <= halted_nxt;
            retired_r      <= retired_nxt;
        end
    end

    assign oMemReq   = mem_req_r;
    assign oMemWe    = mem_we_r;
    assign oMemAddr  = mem_addr_r;
    assign oMemWData = mem_wdata_r;
    assign oIP       = ip_r;
    assign oState    = state_r;
    assign oHalted   = halted_r;
    assign oRetired  = retired_r;

endmodule

// File: tb/tb_subleq_core_param.sv
// Directed bench for subleq_core_param: a behavioural word memory with programmable
// ack delay is serviced from the stimulus process, one negedge per cycle.
module tb_subleq_core_param;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iRun;
    logic        iStep;
    logic        oMemReq;
    logic        oMemWe;
    logic [12:0] oMemAddr;
    logic [63:0] oMemWData;
    logic        iMemAck;
    logic [63:0] iMemRData;
    logic [12:0] oIP;
    logic [2:0]  oState;
    logic        oHalted;
    logic [31:0] oRetired;

    logic [63:0] mem [0:8191];
    int          checks = 0;
    int          failures = 0;
    int          mode = 0;      // 0 zero-wait, 1 random 0..5 waits, 2 fixed 3 waits
    int          wait_cnt = 0;
    int          cur_delay = 0;
    logic        req_was = 1'b0;
    logic        force_ack = 1'b0;

    subleq_core_param dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iRun      (iRun),
        .iStep     (iStep),
        .oMemReq   (oMemReq),
        .oMemWe    (oMemWe),
        .oMemAddr  (oMemAddr),
        .oMemWData (oMemWData),
        .iMemAck   (iMemAck),
        .iMemRData (iMemRData),
        .oIP       (oIP),
        .oState    (oState),
        .oHalted   (oHalted),
        .oRetired  (oRetired)
    );

    initial forever #5 iClock = ~iClock;

    function automatic logic [63:0] enc(input logic [12:0] a, input logic [12:0] b, input logic [12:0] c);
        enc = {25'd0, a, b, c};
    endfunction

    // One clock cycle: service memory at the negedge, then settle so outputs can be sampled.
    task automatic tick();
        @(negedge iClock);
        if (iMemAck || !req_was) begin
            wait_cnt  = 0;
            cur_delay = (mode == 1) ? int'($urandom_range(0, 5)) : ((mode == 2) ? 3 : 0);
        end else begin
            wait_cnt++;
        end
        req_was = oMemReq;
        if (force_ack) begin
            iMemAck   = 1'b1;
            iMemRData = 64'h0;
        end else if (oMemReq && wait_cnt >= cur_delay) begin
            iMemAck   = 1'b1;
            iMemRData = mem[oMemAddr];
            if (oMemWe) mem[oMemAddr] = oMemWData;
        end else begin
            iMemAck   = 1'b0;
            iMemRData = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
    endtask

    task automatic wait_retired(input logic [31:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (oRetired == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_program();
        for (int i = 0; i < 8192; i++) mem[i] = 64'h0;
        mem[0]  = enc(13'd10, 13'd11, 13'd5);
        mem[1]  = enc(13'd12, 13'd13, 13'd5);
        mem[5]  = enc(13'd14, 13'd15, 13'd9);
        mem[9]  = enc(13'd16, 13'd16, 13'd9);
        mem[10] = 64'd3;
        mem[11] = 64'd7;
        mem[12] = 64'd9;
        mem[13] = 64'd2;
        mem[14] = 64'h8000_0000_0000_0000;
        mem[15] = 64'h8000_0000_0000_0000;
        mem[16] = 64'd42;
    endtask

    task automatic test_reset();
        iRun = 1'b0; iStep = 1'b0; iMemAck = 1'b0; iMemRData = 64'h0;
        do_reset();
        tick();
        checks++; if (oIP !== 13'd0)       begin failures++; $display("FAIL reset_ip got=%0h exp=0", oIP); end
        checks++; if (oState !== 3'd0)     begin failures++; $display("FAIL reset_state got=%0d exp=0", oState); end
        checks++; if (oMemReq !== 1'b0)    begin failures++; $display("FAIL reset_req got=%b exp=0", oMemReq); end
        checks++; if (oMemWe !== 1'b0)     begin failures++; $display("FAIL reset_we got=%b exp=0", oMemWe); end
        checks++; if (oMemAddr !== 13'd0)  begin failures++; $display("FAIL reset_addr got=%0h exp=0", oMemAddr); end
        checks++; if (oMemWData !== 64'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", oMemWData); end
        checks++; if (oHalted !== 1'b0)    begin failures++; $display("FAIL reset_halted got=%b exp=0", oHalted); end
        checks++; if (oRetired !== 32'd0)  begin failures++; $display("FAIL reset_retired got=%0d exp=0", oRetired); end
    endtask

    // First instruction with a one-cycle iRun pulse: it must complete and then idle.
    task automatic test_zero_wait();
        int n;
        load_program();
        mode = 0;
        iRun = 1'b1;
        tick();
        iRun = 1'b0;
        checks++; if (oMemReq !== 1'b1 || oMemAddr !== 13'd0) begin failures++; $display("FAIL zw_fetch_req got=%b/%0h exp=1/0", oMemReq, oMemAddr); end
        n = 0;
        while (oRetired !== 32'd1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != 4)              begin failures++; $display("FAIL zw_latency got=%0d exp=4", n); end
        checks++; if (mem[11] !== 64'd4)   begin failures++; $display("FAIL zw_mem11 got=%0h exp=4", mem[11]); end
        checks++; if (oIP !== 13'd1)       begin failures++; $display("FAIL zw_ip got=%0d exp=1", oIP); end
        tick(); tick();
        checks++; if (oMemReq !== 1'b0 || oState !== 3'd0) begin failures++; $display("FAIL zw_idle got=%b/%0d exp=0/0", oMemReq, oState); end
    endtask

    task automatic test_negative();
        bit ok;
        iRun = 1'b1;
        tick();
        iRun = 1'b0;
        wait_retired(32'd2, 30, ok);
        checks++; if (!ok)                             begin failures++; $display("FAIL neg_timeout got=%0d exp=2", oRetired); end
        checks++; if (mem[13] !== 64'hFFFF_FFFF_FFFF_FFF9) begin failures++; $display("FAIL neg_mem13 got=%0h exp=fffffffffffffff9", mem[13]); end
        checks++; if (oIP !== 13'd5)                   begin failures++; $display("FAIL neg_ip got=%0d exp=5", oIP); end
    endtask

    task automatic test_zero_result();
        bit ok;
        iRun = 1'b1;
        tick();
        iRun = 1'b0;
        wait_retired(32'd3, 30, ok);
        checks++; if (!ok)               begin failures++; $display("FAIL zero_timeout got=%0d exp=3", oRetired); end
        checks++; if (mem[15] !== 64'd0) begin failures++; $display("FAIL zero_mem15 got=%0h exp=0", mem[15]); end
        checks++; if (oIP !== 13'd9)     begin failures++; $display("FAIL zero_ip got=%0d exp=9", oIP); end
    endtask

    task automatic test_self_jump_halt();
        int n;
        bit saw_req;
        iRun = 1'b1;
        n = 0;
        while (oHalted !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++; if (oHalted !== 1'b1)   begin failures++; $display("FAIL halt_reached got=%b exp=1", oHalted); end
        checks++; if (mem[16] !== 64'd0)  begin failures++; $display("FAIL halt_write got=%0h exp=0", mem[16]); end
        checks++; if (oIP !== 13'd9)      begin failures++; $display("FAIL halt_ip got=%0d exp=9", oIP); end
        checks++; if (oState !== 3'd4)    begin failures++; $display("FAIL halt_state got=%0d exp=4", oState); end
        checks++; if (oRetired !== 32'd4) begin failures++; $display("FAIL halt_retired got=%0d exp=4", oRetired); end
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (oMemReq) saw_req = 1'b1;
        end
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        tick();
        if (oMemReq) saw_req = 1'b1;
        checks++; if (saw_req !== 1'b0)   begin failures++; $display("FAIL halt_no_req got=%b exp=0", saw_req); end
        checks++; if (oState !== 3'd4 || oIP !== 13'd9) begin failures++; $display("FAIL halt_step_ignored got=%0d/%0d exp=4/9", oState, oIP); end
        iRun = 1'b0;
        do_reset();
        checks++; if (oIP !== 13'd0 || oHalted !== 1'b0 || oState !== 3'd0) begin failures++; $display("FAIL halt_reset got=%0d/%b/%0d exp=0/0/0", oIP, oHalted, oState); end
    endtask

    // Same program under random ack delays; request fields must hold while waiting.
    task automatic test_wait_states();
        int n;
        logic prev_req, prev_ack, prev_we;
        logic [12:0] prev_addr;
        logic [63:0] prev_wdata;
        load_program();
        do_reset();
        mode = 1;
        iRun = 1'b1;
        prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; prev_addr = 13'd0; prev_wdata = 64'd0;
        n = 0;
        while (oHalted !== 1'b1 && n < 600) begin
            tick();
            n++;
            if (prev_req && !prev_ack && oMemReq) begin
                checks++;
                if (oMemAddr !== prev_addr || oMemWe !== prev_we || oMemWData !== prev_wdata) begin
                    failures++;
                    $display("FAIL ws_stable got=%0h/%b/%0h exp=%0h/%b/%0h", oMemAddr, oMemWe, oMemWData, prev_addr, prev_we, prev_wdata);
                end
            end
            prev_req = oMemReq; prev_ack = iMemAck; prev_we = oMemWe; prev_addr = oMemAddr; prev_wdata = oMemWData;
        end
        iRun = 1'b0;
        mode = 0;
        checks++; if (oHalted !== 1'b1)    begin failures++; $display("FAIL ws_halted got=%b exp=1", oHalted); end
        checks++; if (mem[11] !== 64'd4)   begin failures++; $display("FAIL ws_mem11 got=%0h exp=4", mem[11]); end
        checks++; if (mem[13] !== 64'hFFFF_FFFF_FFFF_FFF9) begin failures++; $display("FAIL ws_mem13 got=%0h exp=fffffffffffffff9", mem[13]); end
        checks++; if (mem[15] !== 64'd0 || mem[16] !== 64'd0) begin failures++; $display("FAIL ws_mem15_16 got=%0h/%0h exp=0/0", mem[15], mem[16]); end
        checks++; if (oIP !== 13'd9 || oRetired !== 32'd4) begin failures++; $display("FAIL ws_ip_ret got=%0d/%0d exp=9/4", oIP, oRetired); end
    endtask

    task automatic test_reset_abort();
        int n;
        load_program();
        do_reset();
        mode = 2;
        iRun = 1'b1;
        n = 0;
        while (oState !== 3'd2 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (oState !== 3'd2) begin failures++; $display("FAIL ra_reach_loadb got=%0d exp=2", oState); end
        tick();
        iReset = 1'b1;
        iRun = 1'b0;
        tick();
        checks++; if (oMemReq !== 1'b0 || oMemWe !== 1'b0 || oMemAddr !== 13'd0 || oMemWData !== 64'd0) begin
            failures++; $display("FAIL ra_mem_outs got=%b/%b/%0h/%0h exp=0/0/0/0", oMemReq, oMemWe, oMemAddr, oMemWData);
        end
        checks++; if (oIP !== 13'd0 || oState !== 3'd0 || oHalted !== 1'b0 || oRetired !== 32'd0) begin
            failures++; $display("FAIL ra_core_outs got=%0d/%0d/%b/%0d exp=0/0/0/0", oIP, oState, oHalted, oRetired);
        end
        iReset = 1'b0;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        tick();
        checks++; if (oState !== 3'd0 || oMemReq !== 1'b0 || oRetired !== 32'd0 || oIP !== 13'd0) begin
            failures++; $display("FAIL ra_late_ack got=%0d/%b/%0d/%0d exp=0/0/0/0", oState, oMemReq, oRetired, oIP);
        end
        checks++; if (mem[11] !== 64'd7) begin failures++; $display("FAIL ra_no_write got=%0h exp=7", mem[11]); end
        mode = 0;
    endtask

    task automatic test_step();
        bit ok;
        bit saw_req;
        for (int i = 0; i < 8192; i++) mem[i] = 64'h0;
        mem[0]  = enc(13'd20, 13'd21, 13'd7);
        mem[20] = 64'd1;
        mem[21] = 64'd10;
        iRun = 1'b0;
        do_reset();
        saw_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oMemReq) saw_req = 1'b1;
        end
        checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL step_idle got=%b exp=0", saw_req); end
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        checks++; if (oMemReq !== 1'b1) begin failures++; $display("FAIL step_req got=%b exp=1", oMemReq); end
        tick();
        tick();
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        wait_retired(32'd1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL step_timeout got=%0d exp=1", oRetired); end
        saw_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (oMemReq) saw_req = 1'b1;
        end
        checks++; if (saw_req !== 1'b0 || oRetired !== 32'd1) begin failures++; $display("FAIL step_one_only got=%b/%0d exp=0/1", saw_req, oRetired); end
        checks++; if (oIP !== 13'd1 || mem[21] !== 64'd9 || oState !== 3'd0) begin failures++; $display("FAIL step_result got=%0d/%0h/%0d exp=1/9/0", oIP, mem[21], oState); end
    endtask

    task automatic test_wrap();
        bit ok;
        for (int i = 0; i < 8192; i++) mem[i] = 64'h0;
        mem[0]    = enc(13'd30, 13'd31, 13'd8191);
        mem[30]   = 64'd5;
        mem[31]   = 64'd5;
        mem[8191] = enc(13'd32, 13'd33, 13'd100);
        mem[32]   = 64'd1;
        mem[33]   = 64'd5;
        iRun = 1'b0;
        do_reset();
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        wait_retired(32'd1, 20, ok);
        checks++; if (!ok || oIP !== 13'd8191 || mem[31] !== 64'd0) begin failures++; $display("FAIL wrap_first got=%0d/%0h exp=8191/0", oIP, mem[31]); end
        tick();
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        wait_retired(32'd2, 20, ok);
        checks++; if (!ok || oIP !== 13'd0) begin failures++; $display("FAIL wrap_ip got=%0d exp=0", oIP); end
        checks++; if (mem[33] !== 64'd4)    begin failures++; $display("FAIL wrap_mem33 got=%0h exp=4", mem[33]); end
    endtask

    initial begin
        iReset = 1'b1;
        iRun = 1'b0;
        iStep = 1'b0;
        iMemAck = 1'b0;
        iMemRData = 64'h0;
        test_reset();
        test_zero_wait();
        test_negative();
        test_zero_result();
        test_self_jump_halt();
        test_wait_states();
        test_reset_abort();
        test_step();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
